// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for mem_port_arbiter.
// Optional loader burst lock is enabled by MEMARB_LOCK_EN.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int RD_LAT_DEF = 1;
  localparam int LOCK_MAX   = 16;
  localparam int LOCK_CW    = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin pick with LastGnt flop (+ lock counter).
// Ports: clk_i/rst_ni, req0_i/req1_i, upd_i/id_i (served access), lock_i
// (only with MEMARB_LOCK_EN), pick_o (0 = CPU, 1 = loader).
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic id_i,
`ifdef MEMARB_LOCK_EN
  input  logic lock_i,
`endif
  output logic pick_o
);

  logic last_q, last_d;
  logic pref1;

`ifdef MEMARB_LOCK_EN
  localparam logic [LOCK_CW-1:0] CMAX = LOCK_CW'(LOCK_MAX);

  logic [LOCK_CW-1:0] cnt_q, cnt_d;

  // Count saturates at CMAX; only a CPU grant or an unlocked
  // loader completion clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_i) begin
      if (id_i && lock_i) begin
        if (cnt_q != CMAX) cnt_d = cnt_q + LOCK_CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign pref1 = (cnt_q != '0 && cnt_q != CMAX) ? 1'b1 : ~last_q;
`else
  assign pref1 = ~last_q;
`endif

  assign last_d = upd_i ? id_i : last_q;
  assign pick_o = (req0_i & req1_i) ? pref1 : req1_i;

  // Reset to loader so the CPU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU/loader arbiter for one memory port, Moore FSM.
// Ports: CLK, CtrlRstN; Req/Wr/Addr/WData 0,1 in; Gnt/Done 0,1, RData,
// CPUStall out; MemRead/MemWrite/MemAddr/MemWData out, MemRData in;
// Lock1 in only when MEMARB_LOCK_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              CLK,
  input  logic              CtrlRstN,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
`ifdef MEMARB_LOCK_EN
  input  logic              Lock1,
`endif
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] RData,
  output logic              CPUStall,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              win_q, win_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              pick;
  logic              upd;

  assign upd = (state_q == DONE);

  mem_arb_rr u_rr (
    .clk_i  (CLK),
    .rst_ni (CtrlRstN),
    .req0_i (Req0),
    .req1_i (Req1),
    .upd_i  (upd),
    .id_i   (win_q),
`ifdef MEMARB_LOCK_EN
    .lock_i (Lock1),
`endif
    .pick_o (pick)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (Req0 | Req1) begin
          win_d   = pick;
          wr_d    = pick ? Wr1 : Wr0;
          addr_d  = pick ? Addr1 : Addr0;
          wdata_d = pick ? WData1 : WData0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = wr_q ? DONE : WAIT;
      end
      WAIT: begin
        // Read data is valid on the last of RD_LAT wait cycles.
        if (wcnt_q == LAT_M1) begin
          rdata_d = MemRData;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CtrlRstN) begin
    if (!CtrlRstN) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign Gnt0     = (state_q != IDLE) & ~win_q;
  assign Gnt1     = (state_q != IDLE) &  win_q;
  assign Done0    = (state_q == DONE) & ~win_q;
  assign Done1    = (state_q == DONE) &  win_q;
  assign MemRead  = (state_q == ISSUE) & ~wr_q;
  assign MemWrite = (state_q == ISSUE) &  wr_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign RData    = rdata_q;
  assign CPUStall = Req0 & ~Done0;

endmodule
